// File: rtl/fft_stride_perm.sv
// Radix-4 inter-stage transpose: 4-beat x 4-lane complex frames are emitted with beat/lane swapped.
// Latency is 5 cycles from ctrl_in to ctrl_out. There is no backpressure; ping-pong banks sustain full rate.
module fft_stride_perm #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_in,
  input  logic [4*DATA_WIDTH-1:0]   x_in,
  input  logic [4*DATA_WIDTH-1:0]   y_in,
  output logic                      ctrl_out,
  output logic                      valid_out,
  output logic [4*DATA_WIDTH-1:0]   x_out,
  output logic [4*DATA_WIDTH-1:0]   y_out
);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  typedef logic [3:0][DATA_WIDTH-1:0] lanes_t;

  wstate_t    wstate_q, wstate_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic       wbank_q, wbank_d;
  rstate_t    rstate_q, rstate_d;
  logic [1:0] rcnt_q, rcnt_d;
  logic       rbank_q, rbank_d;
  lanes_t     x_out_q, x_out_d, y_out_q, y_out_d;
  logic       ctrl_out_q, ctrl_out_d;
  logic       valid_out_q, valid_out_d;

  // Banks indexed [bank][beat]; packed index 3 is lane a.
  lanes_t     mem_x_q [2][4];
  lanes_t     mem_y_q [2][4];

  logic       we;
  logic [1:0] waddr;
  logic       frame_done;

  always_comb begin
    wstate_d   = wstate_q;
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    we         = 1'b0;
    waddr      = wcnt_q;
    frame_done = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (ctrl_in) begin
          we       = 1'b1;
          waddr    = 2'd0;
          wcnt_d   = 2'd1;
          wstate_d = W_FILL;
        end
      end
      W_FILL: begin
        we = 1'b1;
        // ctrl_in on beat 3 belongs to the current frame, not a restart.
        if (ctrl_in && (wcnt_q != 2'd3)) begin
          waddr  = 2'd0;
          wcnt_d = 2'd1;
        end else begin
          waddr  = wcnt_q;
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            frame_done = 1'b1;
            wbank_d    = ~wbank_q;
            wstate_d   = W_IDLE;
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d    = rstate_q;
    rcnt_d      = rcnt_q;
    rbank_d     = rbank_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    ctrl_out_d  = 1'b0;
    valid_out_d = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (frame_done) begin
          rbank_d  = wbank_q;
          rcnt_d   = 2'd0;
          rstate_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        valid_out_d = 1'b1;
        ctrl_out_d  = (rcnt_q == 2'd0);
        // Output lane l takes stored beat l, lane rcnt; lane rcnt sits at packed index ~rcnt.
        x_out_d[3]  = mem_x_q[rbank_q][0][~rcnt_q];
        x_out_d[2]  = mem_x_q[rbank_q][1][~rcnt_q];
        x_out_d[1]  = mem_x_q[rbank_q][2][~rcnt_q];
        x_out_d[0]  = mem_x_q[rbank_q][3][~rcnt_q];
        y_out_d[3]  = mem_y_q[rbank_q][0][~rcnt_q];
        y_out_d[2]  = mem_y_q[rbank_q][1][~rcnt_q];
        y_out_d[1]  = mem_y_q[rbank_q][2][~rcnt_q];
        y_out_d[0]  = mem_y_q[rbank_q][3][~rcnt_q];
        rcnt_d      = rcnt_q + 2'd1;
        if (rcnt_q == 2'd3) begin
          if (frame_done) begin
            rbank_d = wbank_q;
            rcnt_d  = 2'd0;
          end else begin
            rstate_d = R_IDLE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q    <= W_IDLE;
      wcnt_q      <= 2'd0;
      wbank_q     <= 1'b0;
      rstate_q    <= R_IDLE;
      rcnt_q      <= 2'd0;
      rbank_q     <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      ctrl_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      rstate_q    <= rstate_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      ctrl_out_q  <= ctrl_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Storage is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_x_q[wbank_q][waddr] <= x_in;
      mem_y_q[wbank_q][waddr] <= y_in;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign ctrl_out  = ctrl_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_fft_stride_perm.sv
// Scoreboarded bench for fft_stride_perm: directed frames push expected beats; a negedge monitor compares.
module tb_fft_stride_perm;

  logic        clk;
  logic        rst;
  logic        ctrl_in;
  logic [63:0] x_in, y_in;
  logic        ctrl_out, valid_out;
  logic [63:0] x_out, y_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int vcnt = 0;

  typedef struct {
    int          cyc;
    logic        ctrl;
    logic [63:0] x;
    logic [63:0] y;
  } exp_t;

  exp_t q[$];
  exp_t e;

  fft_stride_perm #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .x_in(x_in), .y_in(y_in),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .x_out(x_out), .y_out(y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // kind 0: counting pattern with frame index in [15:12]; kind 1: full-scale alternating.
  function automatic logic [15:0] in_lane(input int kind, input int f, input int t, input int l);
    logic [3:0] fb, tb4, lb;
    fb = 4'(f); tb4 = 4'(t); lb = 4'(l);
    if (kind == 0) return {fb, tb4, 4'h0, lb};
    return (l % 2 == 1) ? 16'h8000 : 16'h7FFF;
  endfunction

  function automatic logic [15:0] exp_lane(input int kind, input int f, input int t, input int l);
    logic [3:0] fb, tb4, lb;
    fb = 4'(f); tb4 = 4'(t); lb = 4'(l);
    if (kind == 0) return {fb, lb, 4'h0, tb4};
    return (t % 2 == 1) ? 16'h8000 : 16'h7FFF;
  endfunction

  function automatic logic [15:0] imag_of(input int kind, input logic [15:0] re);
    if (kind == 0) return re ^ 16'h8000;
    return ~re;
  endfunction

  function automatic logic [63:0] pack_x(input int kind, input int f, input int t, input bit expd);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < 4; l++)
      v[(3-l)*16 +: 16] = expd ? exp_lane(kind, f, t, l) : in_lane(kind, f, t, l);
    return v;
  endfunction

  function automatic logic [63:0] pack_y(input int kind, input int f, input int t, input bit expd);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < 4; l++)
      v[(3-l)*16 +: 16] = imag_of(kind, expd ? exp_lane(kind, f, t, l) : in_lane(kind, f, t, l));
    return v;
  endfunction

  task automatic step(input logic c, input logic [63:0] x, input logic [63:0] y);
    @(posedge clk);
    #1;
    ctrl_in = c;
    x_in    = x;
    y_in    = y;
  endtask

  task automatic goto(input int c);
    while (cyc < c - 1) step(1'b0, 64'h0, 64'h0);
  endtask

  task automatic send_frame(input int kind, input int f, input int nbeats);
    int   start;
    exp_t ex;
    start = 0;
    for (int t = 0; t < nbeats; t++) begin
      step(t == 0, pack_x(kind, f, t, 1'b0), pack_y(kind, f, t, 1'b0));
      if (t == 0) start = cyc;
    end
    if (nbeats == 4) begin
      for (int t = 0; t < 4; t++) begin
        ex.cyc  = start + 5 + t;
        ex.ctrl = (t == 0);
        ex.x    = pack_x(kind, f, t, 1'b1);
        ex.y    = pack_y(kind, f, t, 1'b1);
        q.push_back(ex);
      end
    end
  endtask

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (cyc >= 55 && cyc <= 86) vcnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out at cycle %0d: valid_out=1 expected 0", cyc);
      end else begin
        e = q.pop_front();
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
        chk("ctrl_out", {63'h0, ctrl_out}, {63'h0, e.ctrl});
        chk("x_out", x_out, e.x);
        chk("y_out", y_out, e.y);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_out at cycle %0d: valid_out=%b expected 1 (beat due at %0d)", cyc, valid_out, e.cyc);
    end
  end

  initial begin
    rst = 1'b1; ctrl_in = 1'b0; x_in = '0; y_in = '0;
    // Reset with ctrl_in asserted: reset must win.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 64'h0, 64'h0);
    step(1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk("rst_valid", {63'h0, valid_out}, 64'h0);
    chk("rst_ctrl", {63'h0, ctrl_out}, 64'h0);
    chk("rst_x", x_out, 64'h0);
    chk("rst_y", y_out, 64'h0);
    step(1'b0, 64'h0, 64'h0);
    rst = 1'b0;

    // Single frame at 10 -> 15..18.
    goto(10);
    send_frame(0, 0, 4);

    // Restart: partial at 30, full frame from 32 -> 37..40.
    goto(30);
    send_frame(0, 1, 2);
    send_frame(0, 2, 4);

    // Back-to-back frames from 50 -> continuous 55..86.
    goto(50);
    for (int f = 0; f < 8; f++) send_frame(0, f, 4);

    // Idle-gap random data without ctrl_in.
    goto(95);
    for (int i = 0; i < 20; i++)
      step(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    @(negedge clk);
    chk("idle_hold_x", x_out, pack_x(0, 7, 3, 1'b1));
    chk("idle_hold_y", y_out, pack_y(0, 7, 3, 1'b1));
    chk("b2b_valid_cnt", 64'(vcnt), 64'd32);

    // Reset mid-drain: frame at 120, rst during cycle 126.
    goto(120);
    send_frame(0, 9, 4);
    goto(126);
    step(1'b0, 64'h0, 64'h0);
    rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > 126) q.pop_back();
    step(1'b0, 64'h0, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {63'h0, valid_out}, 64'h0);
    chk("mid_rst_ctrl", {63'h0, ctrl_out}, 64'h0);
    chk("mid_rst_x", x_out, 64'h0);
    chk("mid_rst_y", y_out, 64'h0);
    goto(140);
    send_frame(0, 10, 4);

    // Full-scale values.
    goto(155);
    send_frame(1, 0, 4);
    goto(170);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stride_perm.md
# fft_stride_perm

Radix-4 inter-stage permutation buffer for the 64-point FFT datapath. It receives four complex lanes (a..d) per cycle from the twiddle multiplier stage as 4-beat frames, where ctrl_in marks beat 0. It emits each frame transposed, so output beat t, lane l equals input beat l, lane t, and the next butterfly stage receives correctly grouped operands. Ping-pong 4x4 storage sustains back-to-back frames at full rate.

## Interface
- DATA_WIDTH, 16, width of each real/imag component (matches twiddle stage output width)
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- ctrl_in  in  1  frame start; high on beat 0 of an input frame
- x_in  in  4*DATA_WIDTH  real parts, lane a in MSBs, lane d in LSBs
- y_in  in  4*DATA_WIDTH  imag parts, same packing
- ctrl_out  out  1  high on output beat 0 only
- valid_out  out  1  high on all 4 output beats
- x_out  out  4*DATA_WIDTH  transposed real parts, lane a in MSBs
- y_out  out  4*DATA_WIDTH  transposed imag parts

## Operation
- Storage: two banks (0/1), each 4 beats x 4 lanes x 2 components; contents are not cleared by reset.
- Write FSM, W_IDLE/W_FILL, 2-bit beat counter wcnt:
  - W_IDLE: ctrl_in=1 -> write beat 0 into bank wbank, wcnt=1, go to W_FILL. Otherwise input ignored.
  - W_FILL: write beat wcnt, wcnt++.
  - On writing beat 3: frame complete; rbank_next=wbank, wbank toggles, read start requested, go to W_IDLE. If ctrl_in=1 in that same cycle, it is beat 3 of the current frame; ctrl_in is only a start in W_IDLE and on restart (below).
  - Restart: ctrl_in=1 while in W_FILL -> current partial frame discarded, this cycle's data written as beat 0 of the same bank, wcnt=1. Partial frames are never output.
- Read FSM, R_IDLE/R_DRAIN, 2-bit counter rcnt:
  - A read start request loads rbank, rcnt=0, and enters R_DRAIN.
  - R_DRAIN: for each lane l, output register lane l <= bank[rbank][beat l][lane rcnt]; rcnt++.
  - After rcnt=3, return to R_IDLE unless a new start request is pending in the same cycle, in which case continue seamlessly with rcnt=0 on the new bank.
- No arithmetic: pure data movement; bit-exact pass-through of all components.
- Frame completions are spaced at least 4 cycles apart by construction, so a completion never collides with an unfinished drain. Write and read never target the same bank simultaneously.

## Timing
- Reset: x_out=0, y_out=0, ctrl_out=0, valid_out=0, both FSMs idle, wbank=0, counters=0; takes effect at the next edge with rst=1. rst wins over a simultaneous ctrl_in.
- ctrl_in with beat 0 at cycle T, beats 1..3 at T+1..T+3 -> output beats 0..3 registered at T+5..T+8. Latency is 5 cycles ctrl_in->ctrl_out.
- ctrl_out=1 at T+5 only; valid_out=1 at T+5..T+8.
- Back-to-back frames (ctrl_in at T, T+4, T+8, ...): valid_out stays continuously high from T+5 onward; ctrl_out pulses every 4 cycles.
- Restart at T+k (k=1..3): output timing is re-referenced to T+k; output from the previous complete frame still in drain is unaffected.
- Reset mid-drain: valid_out/ctrl_out low from the cycle after rst; the pending frame is lost, with no resumption after rst deasserts.
- Outputs are held (last values) while valid_out=0; consumers must qualify with valid_out.

## Test plan
- Single frame: beat t, lane l input x=16'h0100*t+l, y=16'h8000|(16'h0100*t+l), ctrl_in at cycle 10 -> cycles 15..18 output beat t lane l x=16'h0100*l+t, y=16'h8000|(16'h0100*l+t); ctrl_out only at 15; valid_out 15..18.
- Back-to-back: 8 frames with ctrl_in every 4 cycles, frame index in bits [15:12] -> valid_out continuously high 5 cycles after the first ctrl_in for 32 cycles; each frame correctly transposed and in order; no bank corruption.
- Restart: ctrl_in at cycle 10, again at cycle 12 with new pattern -> only the second frame is output, at cycles 17..20; nothing appears at 15.
- Idle-gap inputs: random data without ctrl_in for 20 cycles -> valid_out stays 0 and outputs unchanged.
- Reset mid-drain: rst high at cycle 16 (frame started at 10) -> from cycle 17 valid_out=0, ctrl_out=0, x_out=y_out=0; a new frame at ctrl_in=30 outputs correctly at 35..38.
- Full-scale values: all lanes x=16'h7FFF/16'h8000 alternating, y inverted -> bit-exact transposed output with no sign alteration.
